// File: rtl/fpga_tx_arbiter.sv
// Round-robin arbiter that shares one FPGA-to-FPGA byte transmitter between two byte sources.
// Optional WAIT watchdog with ABORT/err is compiled in by defining FPGA_TX_ARB_TIMEOUT_EN.
module fpga_tx_arbiter #(
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
`ifdef FPGA_TX_ARB_TIMEOUT_EN
    output logic       err,
`endif
    output logic       grant,
    output logic       busy,
    output logic [7:0] tx_data,
    output logic       tx_sent,
    input  logic       tx_finish_sent
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND  = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3
`ifdef FPGA_TX_ARB_TIMEOUT_EN
        ,
        S_ABORT = 3'd4
`endif
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
        $error("fpga_tx_arbiter: TIMEOUT must be in 1..65535");
    end

    state_t     state_q;
    logic       last_q;
    logic       grant_q;
    logic       busy_q;
    logic [7:0] tx_data_q;
    logic       tx_sent_q;
    logic       ack0_q;
    logic       ack1_q;
    logic       win_d;

`ifdef FPGA_TX_ARB_TIMEOUT_EN
    localparam logic [15:0] TERM = 16'(TIMEOUT - 1);
    logic        err_q;
    logic [15:0] cnt_q;
    assign err = err_q;
`endif

    // On a tie the requester that did not win last time is served.
    always_comb begin
        win_d = req1;
        if (req0 && req1) begin
            win_d = ~last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            grant_q   <= 1'b0;
            busy_q    <= 1'b0;
            tx_data_q <= 8'h00;
            tx_sent_q <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
`ifdef FPGA_TX_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
            cnt_q     <= 16'd0;
`endif
        end else begin
            tx_sent_q <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
`ifdef FPGA_TX_ARB_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        state_q   <= S_SEND;
                        grant_q   <= win_d;
                        last_q    <= win_d;
                        tx_data_q <= win_d ? data1 : data0;
                        tx_sent_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_SEND: begin
                    state_q <= S_WAIT;
`ifdef FPGA_TX_ARB_TIMEOUT_EN
                    cnt_q   <= 16'd0;
`endif
                end
                S_WAIT: begin
                    // Completion beats the watchdog when both land on the same edge.
                    if (tx_finish_sent) begin
                        state_q <= S_DONE;
                        ack0_q  <= ~grant_q;
                        ack1_q  <= grant_q;
                    end
`ifdef FPGA_TX_ARB_TIMEOUT_EN
                    else if (cnt_q == TERM) begin
                        state_q <= S_ABORT;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
`endif
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
`ifdef FPGA_TX_ARB_TIMEOUT_EN
                S_ABORT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack0    = ack0_q;
    assign ack1    = ack1_q;
    assign grant   = grant_q;
    assign busy    = busy_q;
    assign tx_data = tx_data_q;
    assign tx_sent = tx_sent_q;

endmodule

// File: tb/tb_fpga_tx_arbiter.sv
// Directed bench for fpga_tx_arbiter; watchdog cases run when FPGA_TX_ARB_TIMEOUT_EN is defined.
module tb_fpga_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       ack0, ack1;
    logic       grant, busy;
    logic [7:0] tx_data;
    logic       tx_sent;
    logic       tx_finish_sent;
`ifdef FPGA_TX_ARB_TIMEOUT_EN
    logic       err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fpga_tx_arbiter #(.TIMEOUT(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .req0           (req0),
        .req1           (req1),
        .data0          (data0),
        .data1          (data1),
        .ack0           (ack0),
        .ack1           (ack1),
`ifdef FPGA_TX_ARB_TIMEOUT_EN
        .err            (err),
`endif
        .grant          (grant),
        .busy           (busy),
        .tx_data        (tx_data),
        .tx_sent        (tx_sent),
        .tx_finish_sent (tx_finish_sent)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then read and inputs driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [7:0] tie_data [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
    logic       tie_gnt  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00; tx_finish_sent = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_busy",    16'(busy),    16'h0);
        check("rst_tx_sent", 16'(tx_sent), 16'h0);
        check("rst_tx_data", 16'(tx_data), 16'h00);
        check("rst_grant",   16'(grant),   16'h0);
        check("rst_ack",     16'({ack1, ack0}), 16'h0);

        // Single request, finish on the 5th WAIT cycle
        req0 = 1'b1; data0 = 8'hA5;
        step();
        check("single_tx_sent", 16'(tx_sent), 16'h1);
        check("single_tx_data", 16'(tx_data), 16'hA5);
        check("single_grant",   16'(grant),   16'h0);
        check("single_busy",    16'(busy),    16'h1);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("single_wait_tx_sent", 16'(tx_sent), 16'h0);
            check("single_wait_ack",     16'({ack1, ack0}), 16'h0);
        end
        step();
        tx_finish_sent = 1'b1;
        step();
        tx_finish_sent = 1'b0;
        req0 = 1'b0;
        check("single_ack", 16'({ack1, ack0}), 16'h1);
        step();
        check("single_idle_ack",  16'({ack1, ack0}), 16'h0);
        check("single_idle_busy", 16'(busy),    16'h0);
        check("single_hold_data", 16'(tx_data), 16'hA5);

        // Tie after reset: alternation 0,1,0,1
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
        for (int k = 0; k < 4; k++) begin
            step();
            check("tie_grant",   16'(grant),   16'(tie_gnt[k]));
            check("tie_tx_data", 16'(tx_data), 16'(tie_data[k]));
            step();
            tx_finish_sent = 1'b1;
            step();
            tx_finish_sent = 1'b0;
            check("tie_ack", 16'({ack1, ack0}), tie_gnt[k] ? 16'h2 : 16'h1);
            if (k == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            step();
            check("tie_idle_busy", 16'(busy), 16'h0);
        end

        // Instant finish: ack 3 cycles after the request edge
        req1 = 1'b1; data1 = 8'h3C;
        step();
        check("inst_tx_data", 16'(tx_data), 16'h3C);
        step();
        tx_finish_sent = 1'b1;
        step();
        tx_finish_sent = 1'b0;
        req1 = 1'b0;
        check("inst_ack", 16'({ack1, ack0}), 16'h2);
        step();

        // Finish pulsed during SEND is ignored
        req0 = 1'b1; data0 = 8'h5A;
        step();
        tx_finish_sent = 1'b1;
        step();
        tx_finish_sent = 1'b0;
        check("send_fin_busy", 16'(busy), 16'h1);
        step();
        check("send_fin_noack", 16'({ack1, ack0}), 16'h0);
        check("send_fin_busy2", 16'(busy), 16'h1);
        tx_finish_sent = 1'b1;
        step();
        tx_finish_sent = 1'b0;
        req0 = 1'b0;
        check("send_fin_ack", 16'({ack1, ack0}), 16'h1);
        step();

        // Reset during WAIT, then tie goes to requester 0
        req0 = 1'b1; data0 = 8'h77;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rstw_busy",    16'(busy),    16'h0);
        check("rstw_tx_sent", 16'(tx_sent), 16'h0);
        check("rstw_ack",     16'({ack1, ack0}), 16'h0);
        check("rstw_tx_data", 16'(tx_data), 16'h00);
        req1 = 1'b1; data1 = 8'h88;
        step();
        check("rstw_grant",   16'(grant),   16'h0);
        check("rstw_tx_data2", 16'(tx_data), 16'h77);
        step();
        check("rstw_noack", 16'({ack1, ack0}), 16'h0);
        tx_finish_sent = 1'b1;
        step();
        tx_finish_sent = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        check("rstw_ack0", 16'({ack1, ack0}), 16'h1);
        step();

`ifdef FPGA_TX_ARB_TIMEOUT_EN
        // Watchdog abort after 8 WAIT cycles, then requester 1 served
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'hC1; data1 = 8'hC2;
        step();
        check("to_grant0", 16'(grant), 16'h0);
        for (int i = 1; i <= 8; i++) begin
            step();
            check("to_wait_err", 16'(err), 16'h0);
        end
        step();
        check("to_err",  16'(err), 16'h1);
        check("to_noack", 16'({ack1, ack0}), 16'h0);
        check("to_busy", 16'(busy), 16'h1);
        step();
        check("to_err_clr", 16'(err), 16'h0);
        check("to_idle",    16'(busy), 16'h0);
        req0 = 1'b0;
        step();
        check("to_grant1",  16'(grant),   16'h1);
        check("to_tx_data", 16'(tx_data), 16'hC2);

        // Finish on the terminal-count cycle wins over the watchdog
        for (int i = 1; i <= 7; i++) begin
            step();
        end
        step();
        tx_finish_sent = 1'b1;
        step();
        tx_finish_sent = 1'b0;
        req1 = 1'b0;
        check("race_ack", 16'({ack1, ack0}), 16'h2);
        check("race_err", 16'(err), 16'h0);
        step();
        check("race_err2", 16'(err), 16'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
